// File: rtl/uart_inst_loader_if.sv
// uart_inst_loader_if: serial-in / RAM-write-out bundle of the boot loader.
//   rx      : UART serial line, idle high
//   we      : instruction RAM write strobe, one cycle per word
//   waddr   : byte address of the written word
//   wdata   : instruction word
//   cpu_rst : core reset, low only once the image is accepted
//   busy    : load in progress
//   done    : sticky, image accepted
//   err     : sticky, load failed
interface uart_inst_loader_if;
    logic        rx;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    modport master (input rx, output we, waddr, wdata, cpu_rst, busy, done, err);
    modport slave (output rx, input we, waddr, wdata, cpu_rst, busy, done, err);
endinterface

// File: rtl/uart_inst_loader.sv
// uart_inst_loader: receives a program image over 8N1 UART and writes it into instruction RAM.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : uart_inst_loader_if.master (rx in; we/waddr/wdata/cpu_rst/busy/done/err out)
//   Image format: 16-bit little-endian word count N, then 4N little-endian payload bytes.
//   Define LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte of the payload.
module uart_inst_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_WORDS  = 1024
) (
    input logic                clk,
    input logic                rst,
    uart_inst_loader_if.master bus
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        LEN_LO, LEN_HI, DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE, ERR
    } ld_state_t;

    rx_state_t     rs;
    ld_state_t     ls;
    logic          rx_s1, rx_s2, rx_q;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rb;
    logic          bv;
    logic [15:0]   len, idx, n;
    logic [1:0]    bcnt;
    logic [23:0]   part;
    logic          fin;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // Word count as it stands once the high length byte arrives.
    assign n   = {rb, len[7:0]};
    assign fin = (ls == DONE) || (ls == ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1       <= 1'b1;
            rx_s2       <= 1'b1;
            rx_q        <= 1'b1;
            rs          <= R_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            rb          <= '0;
            bv          <= 1'b0;
            ls          <= LEN_LO;
            len         <= '0;
            idx         <= '0;
            bcnt        <= '0;
            part        <= '0;
            bus.we      <= 1'b0;
            bus.waddr   <= '0;
            bus.wdata   <= '0;
            bus.cpu_rst <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.err     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            rx_s1  <= bus.rx;
            rx_s2  <= rx_s1;
            rx_q   <= rx_s2;
            bv     <= 1'b0;
            bus.we <= 1'b0;
            case (rs)
                R_IDLE: if (rx_q && !rx_s2) begin
                    rs  <= R_START;
                    cnt <= '0;
                end
                // Mid-start re-check: a line already back high was a glitch.
                R_START: if (cnt == CW'(HALF - 1)) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    rs      <= rx_s2 ? R_IDLE : R_DATA;
                    if (!rx_s2 && !fin) bus.busy <= 1'b1;
                end else cnt <= cnt + 1'b1;
                R_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt     <= '0;
                    rb      <= {rx_s2, rb[7:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'd7) rs <= R_STOP;
                end else cnt <= cnt + 1'b1;
                // Returning to idle right at the stop sample lets a back-to-back start edge be seen.
                R_STOP: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt <= '0;
                    rs  <= R_IDLE;
                    bv  <= rx_s2;
                    if (!rx_s2 && !fin) begin
                        ls       <= ERR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end else cnt <= cnt + 1'b1;
                default: rs <= R_IDLE;
            endcase
            if (bv) begin
                case (ls)
                    LEN_LO: begin
                        len[7:0] <= rb;
                        ls       <= LEN_HI;
                    end
                    LEN_HI: if (n == '0 || {16'd0, n} > 32'(DEPTH_WORDS)) begin
                        ls       <= ERR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        len[15:8] <= rb;
                        ls        <= DATA;
                    end
                    DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum + rb;
`endif
                        bcnt <= bcnt + 1'b1;
                        part <= {rb, part[23:8]};
                        if (bcnt == 2'd3) begin
                            bus.we    <= 1'b1;
                            bus.waddr <= {14'd0, idx, 2'b00};
                            bus.wdata <= {rb, part};
                            idx       <= idx + 1'b1;
                            if (idx == len - 1'b1) begin
`ifdef LOADER_CHECKSUM_EN
                                ls <= CSUM;
`else
                                ls          <= DONE;
                                bus.done    <= 1'b1;
                                bus.cpu_rst <= 1'b0;
                                bus.busy    <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: if (rb == csum) begin
                        ls          <= DONE;
                        bus.done    <= 1'b1;
                        bus.cpu_rst <= 1'b0;
                        bus.busy    <= 1'b0;
                    end else begin
                        ls       <= ERR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_inst_loader.sv
// tb_uart_inst_loader: table-driven and scoreboard checks of the UART instruction loader.
module tb_uart_inst_loader;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_inst_loader_if bus();

    uart_inst_loader #(.CLKS_PER_BIT(CPB), .DEPTH_WORDS(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] n;
        int          bad;
        logic        exp_done;
        logic        exp_err;
        int          exp_we;
    } vec_t;

    wr_t  sb[$];
    wr_t  e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;
    int   we_seen = 0;
    logic we_done = 1'b0;
    logic we_prev_done = 1'b0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            we_seen++;
            we_done = bus.done;
            we_prev_done = prev_done;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: waddr=%h wdata=%h with no write expected", bus.waddr, bus.wdata);
            end else begin
                e = sb.pop_front();
                chk("we_waddr", bus.waddr, e.addr);
                chk("we_wdata", bus.wdata, e.data);
            end
        end
        prev_done = bus.done;
    end

    function automatic logic [31:0] word_of(int k);
        return k == 0 ? 32'h00100513 : k == 1 ? 32'h00200593 : 32'h9E3779B1 * 32'(k + 1);
    endfunction

    function automatic logic [7:0] byte_at(int i, logic [15:0] n);
        logic [31:0] w;
        if (i == 0) return n[7:0];
        if (i == 1) return n[15:8];
        w = word_of((i - 2) / 4);
        return w[8 * ((i - 2) % 4) +: 8];
    endfunction

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        we_seen = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic push_words(input int cnt);
        for (int k = 0; k < cnt; k++) sb.push_back('{32'(k * 4), word_of(k)});
    endtask

    task automatic send_image(input logic [15:0] n, input logic [7:0] csum_delta);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 0; i < 2 + 4 * int'(n); i++) begin
            if (i >= 2) s = s + byte_at(i, n);
            send_byte(byte_at(i, n), 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(s + csum_delta, 1'b1);
`else
        if (csum_delta != 8'd0) send_byte(s, 1'b1);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        int         nb;
        logic [7:0] s;
        do_reset();
        nb = (v.n >= 1 && int'(v.n) <= DEPTH) ? 2 + 4 * int'(v.n) : 10;
        push_words(v.exp_we);
        s = 8'd0;
        for (int i = 0; i < nb; i++) begin
            if (i >= 2) s = s + byte_at(i, v.n);
            send_byte(byte_at(i, v.n), i != v.bad);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(s, 1'b1);
`endif
        repeat (10) @(negedge clk);
        chk($sformatf("vec_n%0d_done", v.n), 32'(bus.done), 32'(v.exp_done));
        chk($sformatf("vec_n%0d_err", v.n), 32'(bus.err), 32'(v.exp_err));
        chk($sformatf("vec_n%0d_cpu_rst", v.n), 32'(bus.cpu_rst), 32'(!v.exp_done));
        chk($sformatf("vec_n%0d_busy", v.n), 32'(bus.busy), 32'd0);
        chk($sformatf("vec_n%0d_we_count", v.n), 32'(we_seen), 32'(v.exp_we));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'd2,  -1, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd0,  -1, 1'b0, 1'b1, 0};
        vecs[2] = '{16'd17, -1, 1'b0, 1'b1, 0};
        vecs[3] = '{16'd16, -1, 1'b1, 1'b0, 16};
        vecs[4] = '{16'd2,   2, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd3,  -1, 1'b1, 1'b0, 3};
        vecs[6] = '{16'd1,   5, 1'b0, 1'b1, 0};
        vecs[7] = '{16'd2,   7, 1'b0, 1'b1, 1};
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_waddr", bus.waddr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);

        // Nominal image: exact done timing relative to the last write.
        do_reset();
        push_words(2);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("nom_busy_mid", 32'(bus.busy), 32'd1);
        for (int i = 2; i < 10; i++) send_byte(byte_at(i, 16'd2), 1'b1);
        repeat (6) @(negedge clk);
        chk("nom_we_count", 32'(we_seen), 32'd2);
        chk("nom_hold_waddr", bus.waddr, 32'h4);
        chk("nom_hold_wdata", bus.wdata, 32'h00200593);
        chk("nom_we_low", 32'(bus.we), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        chk("nom_done_before_csum", 32'(we_done), 32'd0);
        send_byte(8'hE0, 1'b1);
        repeat (6) @(negedge clk);
`else
        chk("nom_done_with_last_we", 32'(we_done), 32'd1);
        chk("nom_done_prev_low", 32'(we_prev_done), 32'd0);
`endif
        chk("nom_done", 32'(bus.done), 32'd1);
        chk("nom_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        chk("nom_busy_end", 32'(bus.busy), 32'd0);
        for (int i = 2; i < 6; i++) send_byte(byte_at(i, 16'd2), 1'b1);
        repeat (6) @(negedge clk);
        chk("after_done_we_count", 32'(we_seen), 32'd2);
        chk("after_done_err", 32'(bus.err), 32'd0);

        // A one-cycle low pulse while idle is not a frame.
        do_reset();
        @(negedge clk);
        bus.rx = 1'b0;
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_err", 32'(bus.err), 32'd0);
        chk("glitch_we_count", 32'(we_seen), 32'd0);
        push_words(2);
        send_image(16'd2, 8'd0);
        repeat (6) @(negedge clk);
        chk("glitch_then_done", 32'(bus.done), 32'd1);

        // Reset mid-word and mid-byte discards the partial load.
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_reset();
        push_words(2);
        send_image(16'd2, 8'd0);
        repeat (6) @(negedge clk);
        chk("midrst_we_count", 32'(we_seen), 32'd2);
        chk("midrst_done", 32'(bus.done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        push_words(2);
        send_image(16'd2, 8'd1);
        repeat (6) @(negedge clk);
        chk("badsum_err", 32'(bus.err), 32'd1);
        chk("badsum_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        chk("badsum_done", 32'(bus.done), 32'd0);
        chk("badsum_we_count", 32'(we_seen), 32'd2);
`endif

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
